wb_ctrl: RTL
============

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: load-response timeout in clock cycles, used only when WB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  decoded instruction present this cycle.
REQ-005 wb_type  input  2  writeback source: 00 ALU, 01 LOAD, 10 PC+4 (JAL/JALR), 11 IMM (LUI).
REQ-006 rd_addr  input  5  destination register of the current instruction.
REQ-007 rd_wen  input  1  instruction writes rd (0 for store/branch).
REQ-008 mem_req  output  1  load request to data memory.
REQ-009 mem_ready  input  1  memory accepts the request this cycle.
REQ-010 mem_rvalid  input  1  load data valid on the dataMem bus this cycle.
REQ-011 sel  output  2  writeback-mux select, same encoding as wb_type.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  5  register-file write address.
REQ-014 stall  output  1  hold PC and decode; upstream keeps the instruction stable while it is high.
REQ-015 ld_err  output  1  one-cycle pulse on load timeout; tied 0 without WB_TIMEOUT_EN.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and WB, encoded 2 bits.
REQ-017 In IDLE with instr_valid=1 and wb_type!=01: sel=wb_type, rf_waddr=rd_addr, rf_we=rd_wen and (rd_addr!=0), all combinational, zero latency, and stall=0.
REQ-018 In IDLE with instr_valid=1 and wb_type=01: latch rd_addr and rd_wen, stall=1, rf_we=0, next state REQ.
REQ-019 REQ: mem_req=1 held until mem_ready=1; then next state WAIT, or WB if mem_rvalid=1 in the same cycle.
REQ-020 WAIT: mem_req=0; on mem_rvalid=1 the next state is WB.
REQ-021 WB: sel=01, rf_waddr=latched rd, rf_we=latched rd_wen and (latched rd!=0), stall=0, next state IDLE; the instruction is released in this cycle.
REQ-022 stall SHALL be 1 in REQ and WAIT, and in the IDLE cycle that accepts a load.
REQ-023 Outside IDLE, instr_valid and wb_type SHALL be ignored.
REQ-024 mem_rvalid in IDLE, REQ (without mem_ready) or WB SHALL be ignored.
REQ-025 A write to x0 SHALL never assert rf_we.
REQ-026 Minimum load latency SHALL be 3 cycles, accept to WB, when mem_ready and mem_rvalid arrive in the first REQ cycle.
REQ-027 In all states other than WB, sel SHALL default to 00 when no instruction is accepted.

Reset
REQ-028 While rst=1: state=IDLE, mem_req=0, rf_we=0, stall=0, sel=00, rf_waddr=0, ld_err=0, latched rd=0, timeout counter=0.
REQ-029 rst asserted mid-load SHALL abandon the load with no register write; any later mem_rvalid is ignored.

Configuration
REQ-030 Macro WB_TIMEOUT_EN, when defined: a counter clears on entry to REQ, counts each cycle in REQ and WAIT, and on reaching TIMEOUT_CYCLES pulses ld_err for 1 cycle and returns to IDLE with no write and stall=0.
REQ-031 Without WB_TIMEOUT_EN: no counter is built, REQ and WAIT wait indefinitely, and ld_err=0.

Structure
REQ-032 The wb_type/sel encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM) and the FSM state encodings SHALL live in the shared package rv32_pkg.
REQ-033 The timeout counter SHALL be a sub-module wb_timeout; wb_ctrl has no other sub-modules.

Verification
REQ-034 ALU instr, rd=5, rd_wen=1 in IDLE -> same cycle: rf_we=1, rf_waddr=5, sel=00, stall=0.
REQ-035 LUI with rd=0 -> sel=11, rf_we=0.
REQ-036 Load rd=7, mem_ready at cycle 1, mem_rvalid at cycle 4 -> mem_req high cycle 1 only, stall high cycles 0-4, WB at cycle 5 with rf_we=1, sel=01, rf_waddr=7.
REQ-037 Load with mem_ready and mem_rvalid both in the first REQ cycle -> WB in the next cycle (3-cycle latency).
REQ-038 rst during WAIT, then mem_rvalid -> IDLE, no rf_we, stall=0.
REQ-039 WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_rvalid -> ld_err pulses once after 8 cycles, state IDLE, no write.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 writeback encodings and controller state encodings.
package rv32_pkg;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } wb_state_e;

    // x0 is hardwired to zero, so a write to it is never enabled.
    function automatic logic rd_writes(input logic wen, input logic [REG_AW-1:0] rd);
        return wen && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_timeout.sv
// Load-response timeout counter; only present when WB_TIMEOUT_EN is defined.
`ifdef WB_TIMEOUT_EN
module wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Fires during the last counted cycle so the controller leaves on that edge.
    assign expired = en && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/wb_ctrl.sv
// Writeback controller: zero-latency ALU/PC4/IMM writeback, multi-cycle load sequencing.
// Optional load timeout with ld_err pulse is built when WB_TIMEOUT_EN is defined.
module wb_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [1:0]        wb_type,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rd_wen,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    output logic [1:0]        sel,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              stall,
    output logic              ld_err
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wen_q, wen_d;
    logic              tmo_c;

`ifdef WB_TIMEOUT_EN
    logic ld_err_q;
    logic ld_err_d;
    logic tmo_clr_c;
    logic tmo_en_c;

    // Counter is held clear while idle, so it starts from zero on entry to REQ.
    assign tmo_clr_c = (state_q == ST_IDLE);
    assign tmo_en_c  = (state_q == ST_REQ) || (state_q == ST_WAIT);

    wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_c),
        .en      (tmo_en_c),
        .expired (tmo_c)
    );

    // The only non-reset path from REQ/WAIT back to IDLE is the timeout.
    assign ld_err_d = tmo_c && !rst && (state_d == ST_IDLE);
    assign ld_err   = ld_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_err_d;
        end
    end
`else
    assign tmo_c  = 1'b0;
    assign ld_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        mem_req  = 1'b0;
        sel      = WB_ALU;
        rf_we    = 1'b0;
        rf_waddr = '0;
        stall    = 1'b0;
        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (wb_type != WB_MEM) begin
                            sel      = wb_type;
                            rf_waddr = rd_addr;
                            rf_we    = rd_writes(rd_wen, rd_addr);
                        end else begin
                            rd_d    = rd_addr;
                            wen_d   = rd_wen;
                            stall   = 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (mem_ready) begin
                        state_d = mem_rvalid ? ST_WB : ST_WAIT;
                    end
                    // Data arriving on the expiry cycle still completes the load.
                    if (tmo_c && (state_d != ST_WB)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    stall = 1'b1;
                    if (mem_rvalid) begin
                        state_d = ST_WB;
                    end else if (tmo_c) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WB: begin
                    sel      = WB_MEM;
                    rf_waddr = rd_q;
                    rf_we    = rd_writes(wen_q, rd_q);
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
        end
    end

endmodule
